// File: rtl/expu_row_accumulator.sv
// Softmax denominator accumulator behind the exponential unit: converts each active lane
// to signed fixed point, keeps a saturating per-row sum and hands it off on the last beat.
//
// state | meaning
// ACCUM | accepting input beats into the running sums
// HOLD  | sums complete, sum_valid_o high until the consumer takes them
module expu_row_accumulator #(
    parameter int unsigned FPFORMAT     = 4,  // fpnew encoding: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT
    parameter int unsigned N_ROWS       = 1,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned ACC_FRACTION = 16,
    parameter int unsigned CNT_WIDTH    = 16,
    localparam int unsigned EXP   = (FPFORMAT == 0) ? 8  : (FPFORMAT == 1) ? 11 :
                                    (FPFORMAT == 2) ? 5  : (FPFORMAT == 3) ? 5  : 8,
    localparam int unsigned MANT  = (FPFORMAT == 0) ? 23 : (FPFORMAT == 1) ? 52 :
                                    (FPFORMAT == 2) ? 10 : (FPFORMAT == 3) ? 2  : 7,
    localparam int unsigned WIDTH = 1 + EXP + MANT
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                enable_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic                                last_i,
    input  logic [N_ROWS-1:0]                   strb_i,
    input  logic [N_ROWS-1:0][WIDTH-1:0]        op_i,
    output logic [N_ROWS-1:0][ACC_WIDTH-1:0]    sum_o,
    output logic [CNT_WIDTH-1:0]                cnt_o,
    output logic [N_ROWS-1:0]                   ovf_o,
    output logic                                sum_valid_o,
    input  logic                                sum_ready_i
);

    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int   BIAS      = (1 << (EXP - 1)) - 1;
    localparam int   SHIFT_OFS = int'(ACC_FRACTION) - int'(MANT) - BIAS;
    localparam int   SAT_SHIFT = int'(ACC_WIDTH) - 1 - int'(MANT);
    localparam acc_t ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                   state_q;
    acc_t   [N_ROWS-1:0]      acc_q, acc_d;
    logic   [N_ROWS-1:0]      ovf_q, ovf_d;
    logic   [CNT_WIDTH-1:0]   cnt_q;

    logic                     sgn;
    logic   [EXP-1:0]         exp_f;
    logic   [MANT-1:0]        man_f;
    int                       shamt;
    logic   [ACC_WIDTH-1:0]   mag;
    logic                     mag_sat;
    acc_t                     val;
    logic signed [ACC_WIDTH:0] sum_ext;

    assign ready_o     = enable_i & (state_q == ACCUM);
    assign sum_valid_o = (state_q == HOLD);
    assign sum_o       = acc_q;
    assign cnt_o       = cnt_q;
    assign ovf_o       = ovf_q;

    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        sgn     = 1'b0;
        exp_f   = '0;
        man_f   = '0;
        shamt   = 0;
        mag     = '0;
        mag_sat = 1'b0;
        val     = '0;
        sum_ext = '0;
        for (int i = 0; i < int'(N_ROWS); i++) begin
            sgn     = op_i[i][WIDTH-1];
            exp_f   = op_i[i][WIDTH-2 -: EXP];
            man_f   = op_i[i][MANT-1:0];
            shamt   = int'(exp_f) + SHIFT_OFS;
            mag     = '0;
            mag_sat = 1'b0;
            if (strb_i[i]) begin
                if (&exp_f) begin
                    // Inf/NaN pins the row: NaN counts as positive
                    acc_d[i] = (!sgn || (|man_f)) ? ACC_MAX : ACC_MIN;
                    ovf_d[i] = 1'b1;
                end else begin
                    if (|exp_f) begin
                        if (shamt >= SAT_SHIFT)
                            mag_sat = 1'b1;
                        else if (shamt >= 0)
                            mag = ACC_WIDTH'({1'b1, man_f}) << shamt;
                        else
                            mag = ACC_WIDTH'({1'b1, man_f}) >> (-shamt);
                    end
                    if (mag_sat)
                        mag = ACC_MAX;
                    val     = sgn ? acc_t'(-mag) : acc_t'(mag);
                    sum_ext = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + {val[ACC_WIDTH-1], val};
                    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
                        acc_d[i] = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                        ovf_d[i] = 1'b1;
                    end else begin
                        acc_d[i] = sum_ext[ACC_WIDTH-1:0];
                    end
                    if (mag_sat)
                        ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= '0;
            cnt_q   <= '0;
        end else if (enable_i) begin
            unique case (state_q)
                ACCUM: begin
                    if (valid_i) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        if (~&cnt_q)
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (last_i)
                            state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (sum_ready_i) begin
                        acc_q   <= '0;
                        ovf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_expu_row_accumulator.sv
// Scoreboard bench for expu_row_accumulator with two FP16ALT lanes.
module tb_expu_row_accumulator;

    logic             clk_i = 1'b0;
    logic             rst_ni, clear_i, enable_i, valid_i, last_i, sum_ready_i;
    logic             ready_o, sum_valid_o;
    logic [1:0]       strb_i;
    logic [1:0][15:0] op_i;
    logic [1:0][31:0] sum_o;
    logic [15:0]      cnt_o;
    logic [1:0]       ovf_o;

    typedef struct {
        longint s0;
        longint s1;
        longint cnt;
        longint ovf;
    } exp_t;

    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    exp_t        sb_q[$];
    longint      m_acc[2];
    logic [1:0]  m_ovf;
    longint      m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] tbl[8] = '{16'h3F80, 16'h3F00, 16'hBF80, 16'h4120,
                            16'hC0A0, 16'h3E80, 16'h0000, 16'h4B00};

    expu_row_accumulator #(
        .FPFORMAT(4), .N_ROWS(2), .ACC_WIDTH(32), .ACC_FRACTION(16), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i), .strb_i(strb_i),
        .op_i(op_i), .sum_o(sum_o), .cnt_o(cnt_o), .ovf_o(ovf_o),
        .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r * 0.5;
        return r;
    endfunction

    task automatic model_lane(input int l, input logic [15:0] x);
        int     e  = int'(x[14:7]);
        int     mm = int'(x[6:0]);
        real    r;
        longint mag = 0;
        longint t;
        if (e == 255) begin
            m_ovf[l] = 1'b1;
            m_acc[l] = (!x[15] || mm != 0) ? AMAX : AMIN;
            return;
        end
        if (e != 0) begin
            // value * 2^16 = (1 + m/128) * 2^(e-127) * 2^16
            r = real'(128 + mm) * pow2(e - 127 + 16 - 7);
            if (r >= 2147483648.0) begin
                mag = AMAX;
                m_ovf[l] = 1'b1;
            end else begin
                mag = longint'($floor(r));
            end
        end
        t = m_acc[l] + (x[15] ? -mag : mag);
        if (t > AMAX) begin t = AMAX; m_ovf[l] = 1'b1; end
        if (t < AMIN) begin t = AMIN; m_ovf[l] = 1'b1; end
        m_acc[l] = t;
    endtask

    task automatic model_reset();
        m_acc[0] = 0;
        m_acc[1] = 0;
        m_ovf    = '0;
        m_cnt    = 0;
    endtask

    task automatic model_beat(input logic [15:0] a, input logic [15:0] b,
                              input logic [1:0] s, input logic l);
        exp_t e;
        if (s[0]) model_lane(0, a);
        if (s[1]) model_lane(1, b);
        if (m_cnt < 65535) m_cnt++;
        if (l) begin
            e.s0 = m_acc[0]; e.s1 = m_acc[1]; e.cnt = m_cnt; e.ovf = longint'(m_ovf);
            sb_q.push_back(e);
            model_reset();
        end
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic [1:0] s, input logic l);
        int n = 0;
        @(negedge clk_i);
        valid_i = 1'b1; op_i[0] = a; op_i[1] = b; strb_i = s; last_i = l;
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_val("accept_wait", longint'(ready_o), 1);
        @(posedge clk_i);
        model_beat(a, b, s, l);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        int   n = 0;
        @(negedge clk_i);
        while (!sum_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_val("sum_valid_latency", n, 0);
        check_val("sb_depth", sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_val("sum0", longint'($signed(sum_o[0])), e.s0);
        check_val("sum1", longint'($signed(sum_o[1])), e.s1);
        check_val("cnt", longint'(cnt_o), e.cnt);
        check_val("ovf", longint'(ovf_o), e.ovf);
        sum_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        sum_ready_i = 1'b0;
        @(negedge clk_i);
        check_val("post_hs_ready", longint'(ready_o), 1);
        check_val("post_hs_valid", longint'(sum_valid_o), 0);
        check_val("post_hs_cnt", longint'(cnt_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pa, pb;
        int          nb;
        rst_ni = 1'b1; clear_i = 1'b0; enable_i = 1'b1; valid_i = 1'b0; last_i = 1'b0;
        sum_ready_i = 1'b0; strb_i = '0; op_i = '0;
        model_reset();
        #2 rst_ni = 1'b0;
        #10;
        check_val("rst_sum0", longint'(sum_o[0]), 0);
        check_val("rst_sum1", longint'(sum_o[1]), 0);
        check_val("rst_cnt", longint'(cnt_o), 0);
        check_val("rst_ovf", longint'(ovf_o), 0);
        check_val("rst_valid", longint'(sum_valid_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_val("rst_ready", longint'(ready_o), 1);

        // basic two-beat sum
        send_beat(16'h3F80, 16'h3F00, 2'b11, 1'b0);
        send_beat(16'h3F00, 16'h3F00, 2'b11, 1'b1);
        check_val("basic_sum0_const", longint'(sum_o[0]), 64'h18000);
        check_val("basic_sum1_const", longint'(sum_o[1]), 64'h10000);
        collect();

        // strobe and sign
        send_beat(16'h3F80, 16'hBF80, 2'b10, 1'b1);
        collect();

        // magnitude saturation and +Inf
        send_beat(16'h4700, 16'h7F80, 2'b11, 1'b1);
        collect();

        // underflow to zero and denormal
        send_beat(16'h3700, 16'h0001, 2'b11, 1'b1);
        collect();

        // addition clamp on lane 0, NaN on lane 1, zero-strobe beat counting
        send_beat(16'h46FE, 16'h7FC0, 2'b11, 1'b0);
        send_beat(16'h46FE, 16'h3F80, 2'b01, 1'b0);
        send_beat(16'h3F80, 16'h3F80, 2'b00, 1'b1);
        collect();

        // negative clamp
        send_beat(16'hC6FE, 16'hC6FE, 2'b11, 1'b0);
        send_beat(16'hC6FE, 16'h3F80, 2'b11, 1'b1);
        collect();

        // backpressure in HOLD while the next beat waits
        send_beat(16'h4120, 16'hC0A0, 2'b11, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b1; op_i[0] = 16'h3F80; op_i[1] = 16'h3F00; strb_i = 2'b11; last_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            check_val("bp_ready", longint'(ready_o), 0);
            check_val("bp_valid", longint'(sum_valid_o), 1);
            if (sb_q.size() > 0)
                check_val("bp_sum0_stable", longint'($signed(sum_o[0])), sb_q[0].s0);
        end
        collect();
        @(posedge clk_i);
        model_beat(16'h3F80, 16'h3F00, 2'b11, 1'b0);
        #1;
        valid_i = 1'b0;
        check_val("bp_next_cnt", longint'(cnt_o), 1);
        send_beat(16'h3F00, 16'h3F80, 2'b11, 1'b1);
        collect();

        // enable low mid-vector
        send_beat(16'h3F80, 16'h3F80, 2'b11, 1'b0);
        @(negedge clk_i);
        enable_i = 1'b0; valid_i = 1'b1; op_i[0] = 16'h4000; op_i[1] = 16'h4000; strb_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            check_val("en_ready", longint'(ready_o), 0);
            check_val("en_cnt", longint'(cnt_o), 1);
        end
        valid_i = 1'b0;
        enable_i = 1'b1;
        send_beat(16'h3F00, 16'h3F00, 2'b11, 1'b1);
        // enable low in HOLD: sum_ready_i ignored
        enable_i = 1'b0;
        sum_ready_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check_val("en_hold_valid", longint'(sum_valid_o), 1);
            check_val("en_hold_cnt", longint'(cnt_o), 2);
        end
        sum_ready_i = 1'b0;
        enable_i = 1'b1;
        collect();

        // clear while holding
        send_beat(16'h7F80, 16'hFF80, 2'b11, 1'b1);
        @(negedge clk_i);
        check_val("clr_pre_ovf", longint'(ovf_o), 3);
        check_val("clr_pre_sum1", longint'($signed(sum_o[1])), AMIN);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        sb_q.delete();
        check_val("clr_valid", longint'(sum_valid_o), 0);
        check_val("clr_cnt", longint'(cnt_o), 0);
        check_val("clr_sum0", longint'(sum_o[0]), 0);
        check_val("clr_sum1", longint'(sum_o[1]), 0);
        check_val("clr_ovf", longint'(ovf_o), 0);
        check_val("clr_ready", longint'(ready_o), 1);

        // random vectors
        for (int v = 0; v < 8; v++) begin
            nb = int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
                pa = tbl[$urandom_range(0, 7)];
                pb = tbl[$urandom_range(0, 7)];
                send_beat(pa, pb, 2'($urandom_range(0, 3)), (b == nb - 1));
            end
            collect();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
